// File: rtl/mdu_pkg.sv
// mdu_pkg: shared constants for the iterative multiply/divide unit.
// Holds the funct3 op encodings, the FSM state encoding and the
// operand-signedness helpers used when operands are latched.
package mdu_pkg;

    // funct3 encodings of the RV32M/RV64M operations
    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV)  || (op == MDU_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: start/busy/done request bundle between the execute stage
// (master) and the iterative multiply/divide unit (slave).
interface mdu_iter_if #(
    parameter int XLEN = 32
);
    import mdu_pkg::*;

    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );

endinterface

// File: rtl/mdu_divstep.sv
// mdu_divstep: one combinational restoring-division step. Shifts the next
// dividend bit into the partial remainder and subtracts the divisor when it
// fits, producing one quotient bit.
module mdu_divstep
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic            bit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic            q_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    // Trial subtraction one bit wider than the remainder so its MSB is the borrow
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {2'b00, divisor_i};
    assign q_o     = ~diff[XLEN+1];
    assign rem_o   = q_o ? diff[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M/RV64M multiply/divide unit, XLEN+2 cycle latency.
// Works on operand magnitudes (shift-add multiply, restoring divide) and
// applies the sign correction in a final FIX cycle.
// Optional build macro: MDU_FAST_SPECIAL_EN -- divide-by-zero and signed
// overflow complete straight from IDLE (done one cycle after start).
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       reset,
    mdu_iter_if.slave  bus
);

    localparam int CW = $clog2(XLEN + 1);

    logic [1:0]        state_q,   state_d;
    logic [CW-1:0]     cnt_q,     cnt_d;
    logic [2:0]        op_q,      op_d;
    logic              neg_q,     neg_d;      // negate product / quotient
    logic              neg_rem_q, neg_rem_d;  // negate remainder
    logic [XLEN-1:0]   opnd_q,    opnd_d;     // |multiplicand| or |divisor|
    logic [2*XLEN-1:0] acc_q,     acc_d;      // product, or dividend/quotient in low half
    logic [XLEN:0]     rem_q,     rem_d;      // partial remainder
    logic [XLEN-1:0]   result_q,  result_d;

    logic            sa, sb, div_in, b_zero;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   step_rem;
    logic            step_q;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

    // Operand magnitudes and signs, taken from the request in IDLE
    assign sa     = is_signed_a(bus.op) & bus.a[XLEN-1];
    assign sb     = is_signed_b(bus.op) & bus.b[XLEN-1];
    assign mag_a  = sa ? -bus.a : bus.a;
    assign mag_b  = sb ? -bus.b : bus.b;
    assign div_in = bus.op[2];
    assign b_zero = (bus.b == '0);

`ifdef MDU_FAST_SPECIAL_EN
    logic            ovf_in, special_in;
    logic [XLEN-1:0] special_res;

    assign ovf_in = ((bus.op == MDU_DIV) || (bus.op == MDU_REM)) &&
                    (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
    assign special_in  = div_in & (b_zero | ovf_in);
    // Divide by zero: q = all ones, r = a. Overflow: q = a, r = 0.
    assign special_res = b_zero ? (bus.op[1] ? bus.a : '1)
                                : (bus.op[1] ? '0    : bus.a);
`endif

    // Shift-add: add the multiplicand into the high half when the LSB is set
    assign mul_sum = acc_q[0] ? ({1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q})
                              : {1'b0, acc_q[2*XLEN-1:XLEN]};

    mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_i     (rem_q),
        .bit_i     (acc_q[XLEN-1]),
        .divisor_i (opnd_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // Sign correction and result selection for the FIX cycle
    assign prod_fix = neg_q     ? -acc_q             : acc_q;
    assign quot_fix = neg_q     ? -acc_q[XLEN-1:0]   : acc_q[XLEN-1:0];
    assign rem_fix  = neg_rem_q ? -rem_q[XLEN-1:0]   : rem_q[XLEN-1:0];

    always_comb begin
        if (!op_q[2])
            fix_result = (op_q == MDU_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else
            fix_result = op_q[1] ? rem_fix : quot_fix;
    end

    // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence
    always_comb begin
        // NOTE: every next-state signal defaults to its current value first so no
        // path through the case leaves one unassigned and infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d      = bus.op;
                    cnt_d     = CW'(XLEN);
                    // A zero divisor leaves the magnitude quotient all ones, which
                    // must not be negated; a zero product is unaffected either way.
                    neg_d     = (sa ^ sb) & ~b_zero;
                    neg_rem_d = sa;
                    opnd_d    = div_in ? mag_b : mag_a;
                    acc_d     = {{XLEN{1'b0}}, (div_in ? mag_a : mag_b)};
                    rem_d     = '0;
                    state_d   = ST_CALC;
`ifdef MDU_FAST_SPECIAL_EN
                    if (special_in) begin
                        result_d = special_res;
                        state_d  = ST_DONE;
                    end
`endif
                end
            end
            ST_CALC: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (op_q[2]) begin
                        acc_d = {{XLEN{1'b0}}, acc_q[XLEN-2:0], step_q};
                        rem_d = step_rem;
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    if (cnt_q == CW'(1))
                        state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = fix_result;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;  // ST_DONE
        endcase
    end

    // State registers; asynchronous reset clears everything including the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed scoreboard bench for mdu_iter (XLEN=32).
// Stimulus pushes the expected result and completion cycle; a monitor pops
// and compares on every done pulse.
`timescale 1ns/1ps
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 2;
`ifdef MDU_FAST_SPECIAL_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = XLEN + 2;
`endif

    typedef struct {
        logic [XLEN-1:0] res;
        int              cyc;
        string           name;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    logic [XLEN-1:0] last_exp;

    mdu_iter_if #(.XLEN(XLEN)) bus ();

    mdu_iter #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: done high in cycle %0d with no pending op, result 0x%0h",
                         cyc, bus.result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, 64'(bus.result), 64'(e.res));
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at a negedge: issue one start pulse and record its expectation
    task automatic drive_start(input logic [2:0] op, input logic [XLEN-1:0] a,
                               input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                               input int lat, input string name);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        sb.push_back('{exp, cyc + lat, name});
        last_exp  = exp;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.busy === 1'b0 && bus.done === 1'b0)
                return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle_timeout: %0d results still pending at cycle %0d", sb.size(), cyc);
        sb.delete();
    endtask

    task automatic run(input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                       input int lat, input string name);
        @(negedge clk);
        drive_start(op, a, b, exp, lat, name);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int bad;
        n_checks  = 0;
        n_fail    = 0;
        last_exp  = '0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = MDU_MUL;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b0;
        #1 reset  = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_busy",   64'(bus.busy),   64'd0);
        check("reset_done",   64'(bus.done),   64'd0);
        check("reset_result", 64'(bus.result), 64'd0);
        reset = 1'b0;

        // MUL with busy window and latency
        @(negedge clk);
        drive_start(MDU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT, "mul");
        bad = 0;
        for (int k = 1; k <= XLEN + 1; k++) begin
            if (bus.busy !== 1'b1) bad++;
            @(negedge clk);
        end
        check("mul_busy_window", 64'(bad), 64'd0);
        check("mul_busy_in_done", 64'(bus.busy), 64'd0);
        wait_idle();

        // High-half multiplies
        run(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, "mulhu");
        run(MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LAT, "mulh");
        run(MDU_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT, "mulhsu");

        // Divides and remainders
        run(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT, "div");
        run(MDU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT, "rem");
        run(MDU_DIVU, 32'd100,       32'd7, 32'd14,        LAT, "divu");
        run(MDU_REMU, 32'd100,       32'd7, 32'd2,         LAT, "remu");

        // Divide by zero and signed overflow
        run(MDU_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, SPEC_LAT, "divu_by0");
        run(MDU_REMU, 32'd5,         32'd0,         32'd5,         SPEC_LAT, "remu_by0");
        run(MDU_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, SPEC_LAT, "div_by0_neg");
        run(MDU_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, SPEC_LAT, "rem_by0_neg");
        run(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT, "div_ovf");
        run(MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SPEC_LAT, "rem_ovf");
        run(MDU_DIVU, 32'd1000,      32'd3,         32'd333,       LAT,      "divu_1000");

        // Flush in cycle 10 of a DIV; restart in cycle 11
        @(negedge clk);
        c0 = cyc;
        bus.op = MDU_DIV; bus.a = 32'd77; bus.b = 32'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < c0 + 10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy_cleared", 64'(bus.busy), 64'd0);
        check("flush_result_kept", 64'(bus.result), 64'(last_exp));
        drive_start(MDU_DIVU, 32'd100, 32'd7, 32'd14, LAT, "post_flush");
        wait_idle();

        // Flush and start in the same IDLE cycle: nothing starts
        @(negedge clk);
        bus.op = MDU_MUL; bus.a = 32'd3; bus.b = 32'd3;
        bus.start = 1'b1; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start_busy", 64'(bus.busy), 64'd0);
        repeat (3) @(negedge clk);

        // Flush during DONE: done still pulses
        @(negedge clk);
        drive_start(MDU_MUL, 32'd3, 32'd5, 32'd15, LAT, "mul_flush_done");
        c0 = cyc - 1;
        while (cyc < c0 + LAT) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        wait_idle();

        // Start pulses while busy and in DONE are ignored
        @(negedge clk);
        drive_start(MDU_DIVU, 32'd1000, 32'd10, 32'd100, LAT, "divu_ignore");
        c0 = cyc - 1;
        while (cyc < c0 + LAT + 1) begin
            bus.start = (cyc == c0 + 5) || (cyc == c0 + 20) || (cyc == c0 + LAT);
            if (bus.start) begin
                bus.op = MDU_MUL; bus.a = 32'd2; bus.b = 32'd2;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("done_start_ignored", 64'(bus.busy), 64'd0);
        wait_idle();

        // Asynchronous reset in cycle 5 of a MUL
        @(negedge clk);
        drive_start(MDU_MUL, 32'd9, 32'd9, 32'd81, LAT, "mul_reset");
        c0 = cyc - 1;
        while (cyc < c0 + 5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_busy",   64'(bus.busy),   64'd0);
        check("async_reset_done",   64'(bus.done),   64'd0);
        check("async_reset_result", 64'(bus.result), 64'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        run(MDU_DIVU, 32'd100, 32'd7, 32'd14, LAT, "post_reset");
        run(MDU_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, LAT, "mul_wrap");

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
